fifo_uart_tx: RTL and testbench
===============================

Name: fifo_uart_tx

Overview:
Downstream drain stage for the byte FIFO. It pops one byte at a time through the FIFO read port and serialises each byte onto a single UART-style line: 1 start bit, DATA_WIDTH data bits LSB-first, 1 stop bit, no parity. It connects directly to the FIFO outputs `data_out`, `empty` and input `en_read`, and provides the serial output of the buffered data path.

Parameters:
- DATA_WIDTH, 8, width of a FIFO word and number of data bits per frame.
- CLKS_PER_BIT, 16, clk cycles per serial bit. Legal range is 2 or more.

Ports:
- clk, input, 1, system clock. All logic is on the rising edge.
- reset, input, 1, asynchronous active-low reset. All state clears immediately while reset=0.
- enable, input, 1, permits starting new frames.
- fifo_data, input, DATA_WIDTH, FIFO `data_out`. Valid the cycle after fifo_en_read is sampled high (registered read).
- fifo_empty, input, 1, FIFO `empty` flag.
- fifo_en_read, output, 1, FIFO `en_read`. Registered, one-cycle pulse per byte.
- tx, output, 1, serial line. Idle level is 1.
- busy, output, 1, high whenever state is not IDLE.
- frame_done, output, 1, one-cycle pulse on the last clk of the stop bit.

Behaviour:
- Reset values: tx=1, fifo_en_read=0, busy=0, frame_done=0, state=IDLE, bit counter=0, baud counter=0, shift register=0.
- States: IDLE, REQ, LOAD, START, DATA, STOP. All outputs are registered.
- IDLE: tx=1. If enable=1 and fifo_empty=0, go to REQ. Otherwise stay in IDLE.
- REQ: fifo_en_read=1 for exactly this one cycle. Next state is LOAD.
- LOAD: capture fifo_data into the shift register, clear the baud counter, go to START. tx stays 1.
- START: tx=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
- DATA: tx=shift[0] for CLKS_PER_BIT cycles, then shift right and increment the bit index. After bit DATA_WIDTH-1, go to STOP.
- STOP: tx=1 for CLKS_PER_BIT cycles. frame_done=1 on the final cycle. Then go to IDLE.
- Baud counter: counts 0..CLKS_PER_BIT-1 and wraps to 0 at each bit boundary. Width is $clog2(CLKS_PER_BIT).
- Latency: the first start-bit cycle begins 3 clk after the IDLE cycle that sees fifo_empty=0 (IDLE→REQ→LOAD→START).
- Frame period for back-to-back bytes: (DATA_WIDTH+2)*CLKS_PER_BIT + 3 cycles.
- Inter-frame gap: tx=1 for 3 cycles (IDLE, REQ, LOAD) between consecutive frames.
- fifo_en_read is never asserted when fifo_empty was 1 in the deciding IDLE cycle.
- fifo_en_read is never asserted outside REQ. At most one pop per frame.
- fifo_empty and fifo_data are ignored in every state except IDLE (empty) and LOAD (data).
- enable deasserted mid-frame: the current frame completes normally, then the block stays in IDLE and issues no new read.
- enable reasserted: the next frame is decided in the following IDLE cycle.
- Reset asserted mid-frame: tx goes to 1 and fifo_en_read to 0 immediately (asynchronously). The byte in flight is discarded and not re-read.
- After reset release, the block restarts from IDLE on the first rising edge.
- FIFO underflow is impossible by construction: reads only start after fifo_empty=0 is sampled.
- No data-path arithmetic. The shift register is DATA_WIDTH bits and shifts in 0 at the MSB.

Test Plan (CLKS_PER_BIT=4, DATA_WIDTH=8, FIFO instance connected):
- Reset and idle: reset=0 for 2 cycles, then reset=1 with the FIFO empty and enable=1. Required: tx=1, busy=0, fifo_en_read=0 for 50 cycles.
- Single byte: write 8'hA5. Required:
  - exactly one fifo_en_read pulse, 1 cycle wide;
  - tx bits 0,1,0,1,0,0,1,0,1,1, each 4 cycles;
  - frame_done on the last stop cycle;
  - FIFO empty afterwards.
- Back-to-back: write 8'h01, 8'h80, 8'hFF, then enable=1. Required:
  - three read pulses spaced 43 cycles apart;
  - the decoded bytes match in order;
  - 3-cycle tx=1 gaps between frames.
- Enable drop: with 4 bytes queued, drop enable during bit 3 of frame 1. Required: frame 1 completes, no further read, and the FIFO still holds 3 bytes. Reassert enable; the remaining 3 bytes are sent.
- Reset mid-frame: assert reset during bit 5 of 8'h3C. Required:
  - tx=1 and fifo_en_read=0 within the same cycle;
  - busy=0;
  - after release, the next queued byte is transmitted complete, with no partial-frame resume.
- Empty boundary: fill the FIFO to full, enable=1. Required:
  - all bytes are transmitted with the FIFO `full` deasserting after the first pop;
  - there is no read pulse after `empty` rises.

Source files
------------

// File: rtl/fifo_uart_tx.sv
// -----------------------------------------------------------------------------
// fifo_uart_tx
//
// Drain stage for the byte FIFO. Pops one word at a time through the FIFO
// read port and serialises it onto a UART-style line: one start bit (0),
// DATA_WIDTH data bits LSB first, one stop bit (1), no parity.
//
// Parameters:
//   DATA_WIDTH   - FIFO word width and number of data bits per frame
//   CLKS_PER_BIT - clk cycles per serial bit (2 or more)
//
// Ports:
//   clk          - system clock, rising edge
//   reset        - asynchronous active-low reset
//   enable       - permits starting new frames (checked in IDLE only)
//   fifo_data    - FIFO read data, valid the cycle after fifo_en_read
//   fifo_empty   - FIFO empty flag (checked in IDLE only)
//   fifo_en_read - FIFO read strobe, one-cycle pulse per byte
//   tx           - serial line, idles high
//   busy         - high whenever the engine is not idle
//   frame_done   - one-cycle pulse on the last clk of the stop bit
//
// Sequence per byte: IDLE -> REQ (read strobe) -> LOAD (capture word)
// -> START -> DATA x DATA_WIDTH -> STOP -> IDLE. All outputs are registered,
// so each one is assigned on the transition into the state it belongs to.
// -----------------------------------------------------------------------------
module fifo_uart_tx #(
    parameter int DATA_WIDTH   = 8,
    parameter int CLKS_PER_BIT = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic [DATA_WIDTH-1:0] fifo_data,
    input  logic                  fifo_empty,
    output logic                  fifo_en_read,
    output logic                  tx,
    output logic                  busy,
    output logic                  frame_done
);

    localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BIT_W  = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BAUD_W-1:0] BAUD_PRE  = BAUD_W'(CLKS_PER_BIT - 2);
    localparam logic [BAUD_W-1:0] BAUD_ONE  = BAUD_W'(1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_WIDTH - 1);
    localparam logic [BIT_W-1:0]  BIT_ONE   = BIT_W'(1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        REQ   = 3'd1,
        LOAD  = 3'd2,
        START = 3'd3,
        DATA  = 3'd4,
        STOP  = 3'd5
    } state_t;

    state_t                  state_r;
    logic [BAUD_W-1:0]       baud_r;
    logic [BIT_W-1:0]        bit_r;
    logic [DATA_WIDTH-1:0]   shift_r;
    logic [DATA_WIDTH-1:0]   shift_next_s;

    // Next shift-register contents: shift right, zero enters at the MSB.
    assign shift_next_s = shift_r >> 1;

    // Frame sequencer: state, baud/bit counters, shift register and all outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r      <= IDLE;
            baud_r       <= '0;
            bit_r        <= '0;
            shift_r      <= '0;
            fifo_en_read <= 1'b0;
            tx           <= 1'b1;
            busy         <= 1'b0;
            frame_done   <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    tx         <= 1'b1;
                    frame_done <= 1'b0;
                    baud_r     <= '0;
                    bit_r      <= '0;
                    if (enable && !fifo_empty) begin
                        state_r      <= REQ;
                        fifo_en_read <= 1'b1;
                        busy         <= 1'b1;
                    end else begin
                        fifo_en_read <= 1'b0;
                        busy         <= 1'b0;
                    end
                end

                REQ: begin
                    // Strobe is high for exactly the REQ cycle.
                    fifo_en_read <= 1'b0;
                    state_r      <= LOAD;
                end

                LOAD: begin
                    // Registered FIFO read: data is valid now, one cycle after REQ.
                    shift_r <= fifo_data;
                    baud_r  <= '0;
                    tx      <= 1'b0;
                    state_r <= START;
                end

                START: begin
                    if (baud_r == BAUD_LAST) begin
                        baud_r  <= '0;
                        bit_r   <= '0;
                        tx      <= shift_r[0];
                        state_r <= DATA;
                    end else begin
                        baud_r  <= baud_r + BAUD_ONE;
                    end
                end

                DATA: begin
                    if (baud_r == BAUD_LAST) begin
                        baud_r  <= '0;
                        shift_r <= shift_next_s;
                        if (bit_r == BIT_LAST) begin
                            bit_r   <= '0;
                            tx      <= 1'b1;
                            state_r <= STOP;
                        end else begin
                            bit_r   <= bit_r + BIT_ONE;
                            tx      <= shift_next_s[0];
                        end
                    end else begin
                        baud_r  <= baud_r + BAUD_ONE;
                    end
                end

                STOP: begin
                    if (baud_r == BAUD_LAST) begin
                        baud_r     <= '0;
                        busy       <= 1'b0;
                        frame_done <= 1'b0;
                        state_r    <= IDLE;
                    end else begin
                        baud_r     <= baud_r + BAUD_ONE;
                        // Registered pulse: raise it one cycle early so it
                        // lands on the final stop-bit cycle.
                        frame_done <= (baud_r == BAUD_PRE);
                    end
                end

                default: begin
                    state_r      <= IDLE;
                    baud_r       <= '0;
                    bit_r        <= '0;
                    shift_r      <= '0;
                    fifo_en_read <= 1'b0;
                    tx           <= 1'b1;
                    busy         <= 1'b0;
                    frame_done   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// -----------------------------------------------------------------------------
// tb_fifo_uart_tx
//
// Bench for fifo_uart_tx (DATA_WIDTH=8, CLKS_PER_BIT=4) with a queue-based
// registered-read FIFO in front of it. A frame-level reference expands each
// byte the DUT should pop into its expected per-cycle waveform of
// {tx, fifo_en_read, busy, frame_done}; a compare process checks that vector
// every cycle. A line receiver decodes tx back into frames for literal
// checks of bit order, byte order and read-pulse spacing.
// -----------------------------------------------------------------------------
module tb_fifo_uart_tx;

    localparam int DW    = 8;
    localparam int C     = 4;
    localparam int DEPTH = 8;

    localparam logic [3:0] V_IDLE = 4'b1000;  // {tx, en_read, busy, frame_done}

    logic          clk    = 1'b0;
    logic          reset  = 1'b0;
    logic          enable = 1'b1;
    logic [DW-1:0] fifo_data  = '0;
    logic          fifo_empty = 1'b1;
    logic          fifo_full  = 1'b0;
    logic          fifo_en_read;
    logic          tx;
    logic          busy;
    logic          frame_done;

    logic          wr_en   = 1'b0;
    logic [DW-1:0] wr_data = '0;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int fd_cnt = 0;

    logic [DW-1:0] fifo_q[$];
    logic [DW-1:0] push_log[$];
    logic [3:0]    exp_q[$];
    logic [3:0]    exp_vec = V_IDLE;
    logic [9:0]    rx_frames[$];
    int            rd_times[$];

    logic [9:0]    rx_bits   = '0;
    logic          rx_active = 1'b0;
    int            rx_cnt    = 0;

    fifo_uart_tx #(.DATA_WIDTH(DW), .CLKS_PER_BIT(C)) dut (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .fifo_data    (fifo_data),
        .fifo_empty   (fifo_empty),
        .fifo_en_read (fifo_en_read),
        .tx           (tx),
        .busy         (busy),
        .frame_done   (frame_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, want, $time);
        end
    endtask

    // FIFO with registered read port plus write port driven by the stimulus.
    always @(posedge clk) begin
        cyc++;
        if (fifo_en_read && fifo_q.size() != 0) fifo_data <= fifo_q.pop_front();
        if (wr_en && fifo_q.size() < DEPTH) begin
            fifo_q.push_back(wr_data);
            push_log.push_back(wr_data);
        end
        fifo_empty <= (fifo_q.size() == 0);
        fifo_full  <= (fifo_q.size() == DEPTH);
    end

    // Expand one byte into the expected cycle-by-cycle output waveform.
    task automatic build_frame(input logic [DW-1:0] b);
        logic v;
        exp_q.push_back(4'b1110);               // REQ: read strobe
        exp_q.push_back(4'b1010);               // LOAD: line still high
        for (int i = 0; i < DW + 2; i++) begin
            if (i == 0)           v = 1'b0;
            else if (i == DW + 1) v = 1'b1;
            else                  v = b[i-1];
            for (int k = 0; k < C; k++)
                exp_q.push_back({v, 1'b0, 1'b1, ((i == DW + 1) && (k == C - 1))});
        end
        exp_q.push_back(V_IDLE);                // mandatory idle cycle after stop
    endtask

    // Reference: decide a frame when idle with enable and a non-empty FIFO.
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            exp_q.delete();
            exp_vec = V_IDLE;
        end else begin
            if (exp_q.size() == 0 && enable && !fifo_empty) build_frame(fifo_q[0]);
            if (exp_q.size() != 0) exp_vec = exp_q.pop_front();
            else                   exp_vec = V_IDLE;
        end
    end

    // Per-cycle compare against the reference.
    always @(negedge clk) begin
        check("outputs", {28'd0, tx, fifo_en_read, busy, frame_done}, {28'd0, exp_vec});
    end

    // Line receiver and pulse monitors.
    always @(negedge clk) begin
        if (fifo_en_read) rd_times.push_back(cyc);
        if (frame_done)   fd_cnt++;
        if (!reset) begin
            rx_active = 1'b0;
        end else if (!rx_active) begin
            if (tx == 1'b0) begin
                rx_active = 1'b1;
                rx_cnt    = 0;
            end
        end else begin
            rx_cnt++;
        end
        if (rx_active && (rx_cnt % C) == C / 2) begin
            rx_bits[rx_cnt / C] = tx;
            if (rx_cnt / C == DW + 1) begin
                rx_frames.push_back(rx_bits);
                rx_active = 1'b0;
            end
        end
    end

    task automatic push_byte(input logic [DW-1:0] b);
        @(negedge clk);
        wr_en   = 1'b1;
        wr_data = b;
        @(negedge clk);
        wr_en   = 1'b0;
    endtask

    task automatic wait_frames(input int n, input int budget);
        int k = 0;
        while (rx_frames.size() < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        check("frames_seen", rx_frames.size(), n);
    endtask

    task automatic wait_reads(input int n, input int budget);
        int k = 0;
        while (rd_times.size() < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        check("reads_seen", rd_times.size(), n);
    endtask

    task automatic clear_logs();
        rx_frames.delete();
        rd_times.delete();
        fd_cnt = 0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0] bytes[$];
        int r;

        // Reset and idle.
        reset  = 1'b0;
        enable = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (50) @(negedge clk);
        check("idle_tx", tx, 1);
        check("idle_busy", busy, 0);
        check("idle_reads", rd_times.size(), 0);

        // Single byte 0xA5: start, 1,0,1,0,0,1,0,1, stop.
        clear_logs();
        push_byte(8'hA5);
        wait_frames(1, 100);
        repeat (5) @(negedge clk);
        check("a5_reads", rd_times.size(), 1);
        if (rx_frames.size() > 0) check("a5_bits", rx_frames[0], 10'h34A);
        check("a5_frame_done", fd_cnt, 1);
        check("a5_empty", fifo_empty, 1);

        // Back-to-back frames.
        clear_logs();
        enable = 1'b0;
        push_byte(8'h01);
        push_byte(8'h80);
        push_byte(8'hFF);
        enable = 1'b1;
        wait_frames(3, 200);
        if (rd_times.size() == 3) begin
            check("b2b_gap01", rd_times[1] - rd_times[0], 43);
            check("b2b_gap12", rd_times[2] - rd_times[1], 43);
        end
        if (rx_frames.size() == 3) begin
            check("b2b_byte0", rx_frames[0][8:1], 8'h01);
            check("b2b_byte1", rx_frames[1][8:1], 8'h80);
            check("b2b_byte2", rx_frames[2][8:1], 8'hFF);
        end

        // Enable dropped during data bit 3 of the first frame.
        repeat (5) @(negedge clk);
        clear_logs();
        enable = 1'b0;
        bytes = '{8'h11, 8'h22, 8'h33, 8'h44};
        foreach (bytes[i]) push_byte(bytes[i]);
        enable = 1'b1;
        wait_reads(1, 20);
        r = (rd_times.size() > 0) ? rd_times[0] : cyc;
        while (cyc < r + 19) @(negedge clk);   // REQ + 2 + start(4) + 3 bits(12) + 1
        enable = 1'b0;
        wait_frames(1, 100);
        repeat (60) @(negedge clk);
        check("drop_reads", rd_times.size(), 1);
        check("drop_fifo_level", fifo_q.size(), 3);
        enable = 1'b1;
        wait_frames(4, 250);
        if (rx_frames.size() == 4)
            foreach (bytes[i]) check("drop_byte", rx_frames[i][8:1], bytes[i]);

        // Reset during data bit 5 of 0x3C.
        repeat (5) @(negedge clk);
        clear_logs();
        enable = 1'b0;
        push_byte(8'h3C);
        push_byte(8'h5A);
        enable = 1'b1;
        wait_reads(1, 20);
        r = (rd_times.size() > 0) ? rd_times[0] : cyc;
        while (cyc < r + 27) @(negedge clk);
        @(posedge clk);
        #2 reset = 1'b0;
        #1;
        check("rst_tx", tx, 1);
        check("rst_en_read", fifo_en_read, 0);
        check("rst_busy", busy, 0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        wait_frames(1, 100);
        repeat (5) @(negedge clk);
        if (rx_frames.size() > 0) check("rst_next_byte", rx_frames[0][8:1], 8'h5A);
        check("rst_reads", rd_times.size(), 2);
        check("rst_empty", fifo_empty, 1);

        // Fill to full, then drain to empty.
        clear_logs();
        enable = 1'b0;
        bytes.delete();
        for (int i = 0; i < DEPTH; i++) begin
            bytes.push_back(DW'($urandom));
            push_byte(bytes[i]);
        end
        check("full_set", fifo_full, 1);
        enable = 1'b1;
        wait_reads(1, 20);
        repeat (2) @(negedge clk);
        check("full_clear", fifo_full, 0);
        wait_frames(DEPTH, DEPTH * 43 + 50);
        repeat (50) @(negedge clk);
        check("drain_reads", rd_times.size(), DEPTH);
        check("drain_empty", fifo_empty, 1);
        if (rx_frames.size() == DEPTH)
            foreach (bytes[i]) check("drain_byte", rx_frames[i][8:1], bytes[i]);

        // Random pushes and enable toggling.
        clear_logs();
        push_log.delete();
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            wr_en   = (fifo_q.size() < DEPTH - 1) && ($urandom_range(15) == 0);
            wr_data = DW'($urandom);
            if ($urandom_range(63) == 0) enable = ~enable;
        end
        @(negedge clk);
        wr_en  = 1'b0;
        enable = 1'b1;
        wait_frames(push_log.size(), DEPTH * 43 + 200);
        repeat (50) @(negedge clk);
        check("rand_count", rx_frames.size(), push_log.size());
        if (rx_frames.size() == push_log.size())
            foreach (push_log[i]) check("rand_byte", rx_frames[i][8:1], push_log[i]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
